// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - Tomasulo integer ALU reservation station (optional ROB readback via ALU_RS_ROB_FWD_EN)
module alu_reservation_station #(
  parameter int ENTRIES = 4,
  parameter int DATA_W  = 32,
  parameter int ROB_W   = 3,
  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              funcUnitEnable,
  input  logic [2:0]        operatorType,
  input  logic [2:0]        operatorSubType,
  input  logic              operatorFlag,
  input  logic [ROB_W-1:0]  robNum,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [ROB_W-1:0]  q1,
  input  logic [ROB_W-1:0]  q2,
  input  logic              CDBiscast,
  input  logic [ROB_W-1:0]  CDBrobNum,
  input  logic [DATA_W-1:0] CDBdata,
  input  logic              CDBiscast2,
  input  logic [ROB_W-1:0]  CDBrobNum2,
  input  logic [DATA_W-1:0] CDBdata2,
`ifdef ALU_RS_ROB_FWD_EN
  input  logic              robReady1,
  input  logic [DATA_W-1:0] robValue1,
  input  logic              robReady2,
  input  logic [DATA_W-1:0] robValue2,
`endif
  output logic              available,
  output logic [IDX_W-1:0]  index,
  output logic              broadcast,
  output logic [ROB_W-1:0]  robNum_out,
  output logic [DATA_W-1:0] data_out
);

  logic [ENTRIES-1:0] r_busy;
  logic [ENTRIES-1:0] r_rdy1;
  logic [ENTRIES-1:0] r_rdy2;
  logic [2:0]         r_op   [ENTRIES];
  logic [ROB_W-1:0]   r_rob  [ENTRIES];
  logic [ROB_W-1:0]   r_tag1 [ENTRIES];
  logic [ROB_W-1:0]   r_tag2 [ENTRIES];
  logic [DATA_W-1:0]  r_val1 [ENTRIES];
  logic [DATA_W-1:0]  r_val2 [ENTRIES];

  logic               w_avail;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_exec_vld;
  logic [IDX_W-1:0]   w_exec_idx;
  logic [DATA_W-1:0]  w_result;
  logic               w_issue;
  logic               w_iss_rdy1;
  logic               w_iss_rdy2;
  logic [DATA_W-1:0]  w_iss_val1;
  logic [DATA_W-1:0]  w_iss_val2;

  // Lowest free entry is the issue target; availability is purely from current occupancy
  always_comb begin
    w_avail    = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_avail    = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  // Lowest busy entry with both operands already captured goes to execution this edge
  always_comb begin
    w_exec_vld = 1'b0;
    w_exec_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_busy[i] && r_rdy1[i] && r_rdy2[i]) begin
        w_exec_vld = 1'b1;
        w_exec_idx = IDX_W'(i);
      end
    end
  end

  // ALU datapath for the selected entry; unused subtype codes fall back to add
  always_comb begin
    case (r_op[w_exec_idx])
      3'd1:    w_result = r_val1[w_exec_idx] - r_val2[w_exec_idx];
      3'd2:    w_result = r_val1[w_exec_idx] & r_val2[w_exec_idx];
      3'd3:    w_result = r_val1[w_exec_idx] | r_val2[w_exec_idx];
      3'd4:    w_result = r_val1[w_exec_idx] ^ r_val2[w_exec_idx];
      default: w_result = r_val1[w_exec_idx] + r_val2[w_exec_idx];
    endcase
  end

  assign w_issue   = funcUnitEnable && (operatorType == 3'd1) && w_avail;
  assign available = w_avail;
  assign index     = w_free_idx;

  // Operand 1 at issue: register file value, then same-cycle CDB forwarding (adder first)
  always_comb begin
    w_iss_rdy1 = 1'b0;
    w_iss_val1 = data1;
    if (q1 == '0) begin
      w_iss_rdy1 = 1'b1;
    end else if (CDBiscast && (CDBrobNum == q1)) begin
      w_iss_rdy1 = 1'b1;
      w_iss_val1 = CDBdata;
    end else if (CDBiscast2 && (CDBrobNum2 == q1)) begin
      w_iss_rdy1 = 1'b1;
      w_iss_val1 = CDBdata2;
    end
`ifdef ALU_RS_ROB_FWD_EN
    else if (robReady1) begin
      w_iss_rdy1 = 1'b1;
      w_iss_val1 = robValue1;
    end
`endif
  end

  // Operand 2 at issue: immediate form is always ready and ignores q2
  always_comb begin
    w_iss_rdy2 = 1'b0;
    w_iss_val2 = data2;
    if (operatorFlag || (q2 == '0)) begin
      w_iss_rdy2 = 1'b1;
    end else if (CDBiscast && (CDBrobNum == q2)) begin
      w_iss_rdy2 = 1'b1;
      w_iss_val2 = CDBdata;
    end else if (CDBiscast2 && (CDBrobNum2 == q2)) begin
      w_iss_rdy2 = 1'b1;
      w_iss_val2 = CDBdata2;
    end
`ifdef ALU_RS_ROB_FWD_EN
    else if (robReady2) begin
      w_iss_rdy2 = 1'b1;
      w_iss_val2 = robValue2;
    end
`endif
  end

  // Entry state: flush squashes everything, otherwise snoop, retire executed entry, accept issue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_rdy1 <= '0;
      r_rdy2 <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_op[i]   <= '0;
        r_rob[i]  <= '0;
        r_tag1[i] <= '0;
        r_tag2[i] <= '0;
        r_val1[i] <= '0;
        r_val2[i] <= '0;
      end
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (r_busy[i] && !r_rdy1[i]) begin
          if (CDBiscast && (CDBrobNum == r_tag1[i])) begin
            r_rdy1[i] <= 1'b1;
            r_val1[i] <= CDBdata;
          end else if (CDBiscast2 && (CDBrobNum2 == r_tag1[i])) begin
            r_rdy1[i] <= 1'b1;
            r_val1[i] <= CDBdata2;
          end
        end
        if (r_busy[i] && !r_rdy2[i]) begin
          if (CDBiscast && (CDBrobNum == r_tag2[i])) begin
            r_rdy2[i] <= 1'b1;
            r_val2[i] <= CDBdata;
          end else if (CDBiscast2 && (CDBrobNum2 == r_tag2[i])) begin
            r_rdy2[i] <= 1'b1;
            r_val2[i] <= CDBdata2;
          end
        end
        if (w_exec_vld && (w_exec_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b0;
        end
        if (w_issue && (w_free_idx == IDX_W'(i))) begin
          r_busy[i] <= 1'b1;
          r_op[i]   <= operatorSubType;
          r_rob[i]  <= robNum;
          r_rdy1[i] <= w_iss_rdy1;
          r_val1[i] <= w_iss_val1;
          r_tag1[i] <= q1;
          r_rdy2[i] <= w_iss_rdy2;
          r_val2[i] <= w_iss_val2;
          r_tag2[i] <= q2;
        end
      end
    end
  end

  // Result register: one-cycle broadcast pulse, tag/data hold when idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      broadcast  <= 1'b0;
      robNum_out <= '0;
      data_out   <= '0;
    end else if (flush) begin
      broadcast <= 1'b0;
    end else begin
      broadcast <= w_exec_vld;
      if (w_exec_vld) begin
        robNum_out <= r_rob[w_exec_idx];
        data_out   <= w_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - scoreboard bench for alu_reservation_station
module tb_alu_reservation_station;
  localparam int E  = 4;
  localparam int DW = 32;
  localparam int RW = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          flush, fue, flag, c2v;
  logic [2:0]    optype, opsub;
  logic [RW-1:0] rob, q1, q2, c2tag;
  logic [DW-1:0] d1, d2, c2data;
  logic          m_bc;
  logic [RW-1:0] m_bctag;
  logic [DW-1:0] m_bcdata;
  logic          available, broadcast;
  logic [1:0]    index;
  logic [RW-1:0] robNum_out;
  logic [DW-1:0] data_out;

  alu_reservation_station #(.ENTRIES(E), .DATA_W(DW), .ROB_W(RW)) dut (
    .clock(clock), .reset(reset), .flush(flush), .funcUnitEnable(fue),
    .operatorType(optype), .operatorSubType(opsub), .operatorFlag(flag),
    .robNum(rob), .data1(d1), .data2(d2), .q1(q1), .q2(q2),
    .CDBiscast(m_bc), .CDBrobNum(m_bctag), .CDBdata(m_bcdata),
    .CDBiscast2(c2v), .CDBrobNum2(c2tag), .CDBdata2(c2data),
`ifdef ALU_RS_ROB_FWD_EN
    .robReady1(1'b0), .robValue1('0), .robReady2(1'b0), .robValue2('0),
`endif
    .available(available), .index(index), .broadcast(broadcast),
    .robNum_out(robNum_out), .data_out(data_out)
  );

  typedef struct {
    logic [RW-1:0] tag;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // reference model: a bag of waiting ops, each with per-operand pending tag (0 = have value)
  bit            m_busy[E];
  logic [2:0]    m_op[E];
  logic [RW-1:0] m_rob[E], m_p1[E], m_p2[E];
  logic [DW-1:0] m_v1[E], m_v2[E];
  bit            inflight[8];
  bit            loadpend[8];

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  bit mon_off = 1'b1;

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic resolve(input logic [RW-1:0] q, input logic [DW-1:0] d,
                         output logic [RW-1:0] p, output logic [DW-1:0] v);
    p = q;
    v = d;
    if (q == 0) p = 0;
    else if (m_bc && m_bctag == q) begin p = 0; v = m_bcdata; end
    else if (c2v && c2tag == q) begin p = 0; v = c2data; end
  endtask

  // advance one clock: predict, check combinational outputs, clock, commit
  task automatic step();
    int fr, ex;
    bit            n_busy[E];
    logic [RW-1:0] n_p1[E], n_p2[E], n_rob[E];
    logic [DW-1:0] n_v1[E], n_v2[E];
    logic [2:0]    n_op[E];
    bit            n_inf[8];
    logic          n_bc;
    logic [RW-1:0] n_tag, p;
    logic [DW-1:0] n_data, v;
    n_busy = m_busy; n_p1 = m_p1; n_p2 = m_p2; n_rob = m_rob;
    n_v1 = m_v1; n_v2 = m_v2; n_op = m_op; n_inf = inflight;
    n_bc = 1'b0; n_tag = m_bctag; n_data = m_bcdata;
    fr = -1;
    for (int i = E - 1; i >= 0; i--) if (!m_busy[i]) fr = i;
    check("available", {63'd0, available}, (fr >= 0) ? 64'd1 : 64'd0);
    if (fr >= 0) check("index", {62'd0, index}, 64'(fr));
    if (flush) begin
      for (int i = 0; i < E; i++) begin
        if (m_busy[i]) n_inf[m_rob[i]] = 1'b0;
        n_busy[i] = 1'b0;
      end
    end else begin
      ex = -1;
      for (int i = E - 1; i >= 0; i--)
        if (m_busy[i] && m_p1[i] == 0 && m_p2[i] == 0) ex = i;
      if (ex >= 0) begin
        n_busy[ex] = 1'b0;
        n_bc = 1'b1;
        n_tag = m_rob[ex];
        n_data = alu_ref(m_op[ex], m_v1[ex], m_v2[ex]);
        n_inf[m_rob[ex]] = 1'b0;
        exp_q.push_back('{n_tag, n_data, edge_cnt + 1});
      end
      for (int i = 0; i < E; i++) begin
        if (m_busy[i] && m_p1[i] != 0) begin resolve(m_p1[i], m_v1[i], p, v); n_p1[i] = p; n_v1[i] = v; end
        if (m_busy[i] && m_p2[i] != 0) begin resolve(m_p2[i], m_v2[i], p, v); n_p2[i] = p; n_v2[i] = v; end
      end
      if (fue && optype == 3'd1 && fr >= 0) begin
        n_busy[fr] = 1'b1;
        n_op[fr] = opsub;
        n_rob[fr] = rob;
        resolve(q1, d1, p, v); n_p1[fr] = p; n_v1[fr] = v;
        if (flag) begin n_p2[fr] = 0; n_v2[fr] = d2; end
        else begin resolve(q2, d2, p, v); n_p2[fr] = p; n_v2[fr] = v; end
        n_inf[rob] = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    m_busy = n_busy; m_p1 = n_p1; m_p2 = n_p2; m_rob = n_rob;
    m_v1 = n_v1; m_v2 = n_v2; m_op = n_op; inflight = n_inf;
    m_bc = n_bc; m_bctag = n_tag; m_bcdata = n_data;
    edge_cnt++;
    fue = 1'b0; flush = 1'b0; c2v = 1'b0;
  endtask

  task automatic issue(input logic [RW-1:0] r, input logic [2:0] sub, input logic f,
                       input logic [DW-1:0] a, input logic [RW-1:0] qa,
                       input logic [DW-1:0] b, input logic [RW-1:0] qb);
    fue = 1'b1; optype = 3'd1; opsub = sub; flag = f;
    rob = r; d1 = a; q1 = qa; d2 = b; q2 = qb;
  endtask

  function automatic logic [RW-1:0] pick_free();
    logic [RW-1:0] l[$];
    for (int t = 1; t < 8; t++)
      if (!inflight[t] && !loadpend[t] && !(m_bc && m_bctag == RW'(t))) l.push_back(RW'(t));
    if (l.size() == 0) return '0;
    return l[$urandom_range(l.size() - 1)];
  endfunction

  function automatic logic [RW-1:0] pick_cand();
    logic [RW-1:0] l[$];
    for (int t = 1; t < 8; t++)
      if (inflight[t] || loadpend[t] || (m_bc && m_bctag == RW'(t))) l.push_back(RW'(t));
    if (l.size() == 0) return '0;
    return l[$urandom_range(l.size() - 1)];
  endfunction

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 80 && !done; n++) begin
      for (int t = 1; t < 8; t++) begin
        if (loadpend[t] && !c2v) begin c2v = 1'b1; c2tag = RW'(t); c2data = $urandom; loadpend[t] = 1'b0; end
      end
      step();
      done = !m_bc;
      for (int i = 0; i < E; i++) if (m_busy[i]) done = 1'b0;
      for (int t = 1; t < 8; t++) if (loadpend[t]) done = 1'b0;
    end
    check("drain_done", {63'd0, done}, 64'd1);
  endtask

  // monitor: every broadcast pops the scoreboard; stale expectations are misses
  always @(negedge clock) begin
    if (!mon_off) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
        checks++; failures++;
        $display("FAIL bc_missing actual=no_broadcast required=tag%0d data=%0h", exp_q[0].tag, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      if (broadcast) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != edge_cnt) begin
          checks++; failures++;
          $display("FAIL bc_unexpected actual=tag%0d data=%0h required=no_broadcast", robNum_out, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("bc_tag", {61'd0, robNum_out}, {61'd0, mon_e.tag});
          check("bc_data", {32'd0, data_out}, {32'd0, mon_e.data});
        end
      end
    end
  end

  initial begin
    logic [RW-1:0] t, ld;
    reset = 1'b0; flush = 1'b0; fue = 1'b0; flag = 1'b0; c2v = 1'b0;
    optype = 3'd0; opsub = 3'd0; rob = '0; q1 = '0; q2 = '0; d1 = '0; d2 = '0;
    c2tag = '0; c2data = '0; m_bc = 1'b0; m_bctag = '0; m_bcdata = '0;
    for (int i = 0; i < E; i++) begin
      m_busy[i] = 1'b0; m_op[i] = '0; m_rob[i] = '0; m_p1[i] = '0; m_p2[i] = '0; m_v1[i] = '0; m_v2[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin inflight[i] = 1'b0; loadpend[i] = 1'b0; end
    repeat (2) @(posedge clock);
    #1;
    check("rst_broadcast", {63'd0, broadcast}, 64'd0);
    check("rst_robNum_out", {61'd0, robNum_out}, 64'd0);
    check("rst_data_out", {32'd0, data_out}, 64'd0);
    check("rst_available", {63'd0, available}, 64'd1);
    check("rst_index", {62'd0, index}, 64'd0);
    reset = 1'b1;
    mon_off = 1'b0;

    // add 3+5, sub 1-4, xori 5^6 (q2 junk must be ignored)
    issue(3'd2, 3'd0, 1'b0, 32'd3, 3'd0, 32'd5, 3'd0); step();
    issue(3'd3, 3'd1, 1'b0, 32'd1, 3'd0, 32'd4, 3'd0); step();
    issue(3'd4, 3'd4, 1'b1, 32'd5, 3'd0, 32'd6, 3'd7); step();
    drain();

    // operand waiting on a load tag
    loadpend[3] = 1'b1;
    issue(3'd1, 3'd0, 1'b0, 32'hDEAD_BEEF, 3'd3, 32'd7, 3'd0); step();
    step(); step();
    c2v = 1'b1; c2tag = 3'd3; c2data = 32'd10; step(); loadpend[3] = 1'b0;
    drain();

    // fill all four entries behind tag 5, drop a fifth, then release in index order
    loadpend[5] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      issue(RW'(i), 3'(i), 1'b0, 32'd100, 3'd5, 32'(i * 3), 3'd0); step();
    end
    check("full_available", {63'd0, available}, 64'd0);
    issue(3'd6, 3'd0, 1'b0, 32'd1, 3'd0, 32'd1, 3'd0); step();
    c2v = 1'b1; c2tag = 3'd5; c2data = 32'h8000_0001; step(); loadpend[5] = 1'b0;
    drain();

    // flush with three busy entries
    loadpend[6] = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      issue(RW'(i), 3'd0, 1'b0, 32'd0, 3'd6, 32'd1, 3'd0); step();
    end
    flush = 1'b1; step();
    check("flush_available", {63'd0, available}, 64'd1);
    check("flush_index", {62'd0, index}, 64'd0);
    check("flush_broadcast", {63'd0, broadcast}, 64'd0);
    drain();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      ld = '0;
      t = pick_cand();
      for (int k = 1; k < 8; k++) if (loadpend[k] && ld == 0 && $urandom_range(2) == 0) ld = RW'(k);
      if (ld != 0) begin
        c2v = 1'b1; c2tag = ld; c2data = $urandom;
      end else if ($urandom_range(5) == 0) begin
        t = pick_free();
        if (t != 0) loadpend[t] = 1'b1;
      end
      if ($urandom_range(1) == 0) begin
        t = pick_free();
        if (t != 0) begin
          issue(t, 3'($urandom_range(7)), 1'($urandom_range(1)), $urandom,
                ($urandom_range(1) == 0) ? 3'd0 : pick_cand(), $urandom,
                ($urandom_range(1) == 0) ? 3'd0 : pick_cand());
          if (flag) q2 = 3'($urandom_range(7));
          if ($urandom_range(4) == 0) optype = 3'($urandom_range(7));
        end
      end
      if ($urandom_range(199) == 0) flush = 1'b1;
      step();
      if (ld != 0) loadpend[ld] = 1'b0;
    end
    drain();
    @(negedge clock);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // asynchronous reset while a result is on the bus
    issue(3'd7, 3'd0, 1'b0, 32'd40, 3'd0, 32'd2, 3'd0); step();
    step();
    check("pre_reset_broadcast", {63'd0, broadcast}, 64'd1);
    check("pre_reset_data", {32'd0, data_out}, 64'd42);
    mon_off = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("async_broadcast", {63'd0, broadcast}, 64'd0);
    check("async_data_out", {32'd0, data_out}, 64'd0);
    check("async_robNum_out", {61'd0, robNum_out}, 64'd0);
    check("async_available", {63'd0, available}, 64'd1);
    exp_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
